bus_decoder: RTL



---
 rtl/bus_decoder_pkg.sv | 23 ++
 rtl/bus_addr_match.sv | 32 +++
 rtl/bus_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the SoC memory-bus blocks: decoder state encoding,
// error data default and helpers to locate per-slave fields in packed vectors.
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT  = 2'd1,
    ST_ERR  = 2'd2
  } bus_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          TCNT_W           = 16;

  // Lsb position of field i in a vector of packed 32-bit / 4-bit fields.
  function automatic int slice_32(input int i);
    return 32 * i;
  endfunction

  function automatic int slice_4(input int i);
    return 4 * i;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational priority address match against packed base/mask pairs;
// the lowest matching index wins.
module bus_addr_match #(
  parameter int CNT   = 4,
  parameter int IDX_W = (CNT > 1) ? $clog2(CNT) : 1
) (
  input  logic [31:0]       i_addr,
  input  logic [32*CNT-1:0] i_base,
  input  logic [32*CNT-1:0] i_mask,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  logic [CNT-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_match
      assign w_match[gi] = (i_addr & i_mask[32*gi +: 32]) == i_base[32*gi +: 32];
    end
  endgenerate

  always_comb begin
    o_hit = |w_match;
    o_idx = '0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = CNT - 1; i >= 0; i--) begin
      if (w_match[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// Single-master to multi-slave splitter: registered address decode, selection
// held until the master drops valid, error completion for unmapped or stalled accesses.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int                     SLAVE_CNT  = 4,
  parameter logic [32*SLAVE_CNT-1:0] SLAVE_BASE = '0,
  parameter logic [32*SLAVE_CNT-1:0] SLAVE_MASK = '0,
  parameter int                     TIMEOUT    = 255,
  parameter logic [31:0]            ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic                    m_valid,
  input  logic [3:0]              m_wen,
  output logic [31:0]             m_rdata,
  output logic                    m_ready,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wen,
  output logic [SLAVE_CNT-1:0]    s_valid,
  input  logic [32*SLAVE_CNT-1:0] s_rdata,
  input  logic [SLAVE_CNT-1:0]    s_ready,
  output logic                    err,
  output logic [31:0]             err_addr
);

  localparam int SEL_W = $clog2(SLAVE_CNT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  bus_state_e        r_state, w_state_next;
  logic [SEL_W-1:0]  r_sel, w_sel_next;
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_next;
  logic              r_err, w_err_next;
  logic [31:0]       r_err_addr, w_err_addr_next;
  logic              r_given, w_given_next;

  logic              w_hit;
  logic [SEL_W-1:0]  w_idx;
  logic              w_sel_ready;
  logic [31:0]       w_sel_rdata;

  bus_addr_match #(
    .CNT   (SLAVE_CNT),
    .IDX_W (SEL_W)
  ) u_match (
    .i_addr (m_addr),
    .i_base (SLAVE_BASE),
    .i_mask (SLAVE_MASK),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_sel_ready = s_ready[r_sel];
  assign w_sel_rdata = s_rdata[slice_32(int'(r_sel)) +: 32];

  assign s_addr   = m_addr;
  assign s_wdata  = m_wdata;
  assign s_wen    = m_wen;
  assign err      = r_err;
  assign err_addr = r_err_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_given    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      r_tcnt     <= w_tcnt_next;
      r_err      <= w_err_next;
      r_err_addr <= w_err_addr_next;
      r_given    <= w_given_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sel_next      = r_sel;
    w_tcnt_next     = r_tcnt;
    w_err_next      = 1'b0;
    w_err_addr_next = r_err_addr;
    w_given_next    = r_given;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) begin
          if (w_hit) begin
            w_state_next = ST_ACT;
            w_sel_next   = w_idx;
            w_tcnt_next  = '0;
            w_given_next = 1'b0;
          end else begin
            w_state_next    = ST_ERR;
            w_err_next      = 1'b1;
            w_err_addr_next = m_addr;
          end
        end
      end
      ST_ACT: begin
        // Master release beats a simultaneous timeout.
        if (!m_valid) begin
          w_state_next = ST_IDLE;
        end else if (w_sel_ready) begin
          w_given_next = 1'b1;
        end else if (!r_given) begin
          if (r_tcnt == TCNT_LAST) begin
            w_state_next    = ST_ERR;
            w_err_next      = 1'b1;
            w_err_addr_next = m_addr;
          end else begin
            w_tcnt_next = r_tcnt + 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (!m_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid = '0;
    m_ready = 1'b0;
    m_rdata = '0;
    case (r_state)
      ST_ACT: begin
        s_valid[r_sel] = m_valid;
        m_ready        = w_sel_ready;
        m_rdata        = w_sel_rdata;
      end
      ST_ERR: begin
        m_ready = 1'b1;
        m_rdata = ERR_DATA;
      end
      default: ;
    endcase
  end

endmodule
